// File: rtl/page_rank_top.sv
// PageRank accelerator wrapper: sweeps a page range one page per cycle, sums
// degree-scaled base ranks, and exposes activity counters on a perf ring.
module page_rank_top #(
  parameter logic [31:0] INIT_RANK = 32'd1024,
  parameter logic [15:0] MODULE_ID = 16'd1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        io_in_ready,
  input  logic        io_in_valid,
  input  logic        io_in_bits_done,
  input  logic [31:0] io_in_bits_startPageId,
  input  logic [31:0] io_in_bits_length,
  input  logic        io_out_ready,
  output logic        io_out_valid,
  output logic [31:0] io_out_bits_out,
  input  logic        io_pcIn_valid,
  input  logic        io_pcIn_bits_request,
  input  logic [15:0] io_pcIn_bits_moduleId,
  input  logic [7:0]  io_pcIn_bits_portId,
  input  logic [15:0] io_pcIn_bits_pcValue,
  input  logic [3:0]  io_pcIn_bits_pcType,
  output logic        io_pcOut_valid,
  output logic        io_pcOut_bits_request,
  output logic [15:0] io_pcOut_bits_moduleId,
  output logic [7:0]  io_pcOut_bits_portId,
  output logic [15:0] io_pcOut_bits_pcValue,
  output logic [3:0]  io_pcOut_bits_pcType
);

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

  state_t      state_q;
  logic        in_ready_q, out_valid_q;
  logic [31:0] ptr_q, rem_q, acc_q, result_q, jobs_q;
  logic [31:0] cnt_run_q, cnt_in_q, cnt_out_q, cnt_stall_q;

  logic        in_hs, out_hs, out_stall;
  logic [31:0] page_rank, acc_sum;
  logic [31:0] sel_cnt;

  assign in_hs     = io_in_valid & in_ready_q;
  assign out_hs    = out_valid_q & io_out_ready;
  assign out_stall = out_valid_q & ~io_out_ready;

  // Rank of a page is the base rank scaled down by its (ptr mod 4) degree class.
  assign page_rank = INIT_RANK >> ptr_q[1:0];
  assign acc_sum   = acc_q + page_rank;

  assign io_in_ready     = in_ready_q;
  assign io_out_valid    = out_valid_q;
  assign io_out_bits_out = result_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
      rem_q       <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      jobs_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_hs) begin
            if (io_in_bits_done) begin
              result_q    <= jobs_q;
              state_q     <= OUT;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else if (io_in_bits_length == 32'd0) begin
              result_q    <= '0;
              jobs_q      <= jobs_q + 32'd1;
              state_q     <= OUT;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              ptr_q      <= io_in_bits_startPageId;
              rem_q      <= io_in_bits_length;
              acc_q      <= '0;
              state_q    <= RUN;
              in_ready_q <= 1'b0;
            end
          end
        end
        RUN: begin
          acc_q <= acc_sum;
          ptr_q <= ptr_q + 32'd1;
          rem_q <= rem_q - 32'd1;
          if (rem_q == 32'd1) begin
            result_q    <= acc_sum;
            jobs_q      <= jobs_q + 32'd1;
            state_q     <= OUT;
            out_valid_q <= 1'b1;
          end
        end
        OUT: begin
          if (io_out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_run_q   <= '0;
      cnt_in_q    <= '0;
      cnt_out_q   <= '0;
      cnt_stall_q <= '0;
    end else begin
      if (state_q == RUN) cnt_run_q <= cnt_run_q + 32'd1;
      if (in_hs)          cnt_in_q <= cnt_in_q + 32'd1;
      if (out_hs)         cnt_out_q <= cnt_out_q + 32'd1;
      if (out_stall)      cnt_stall_q <= cnt_stall_q + 32'd1;
    end
  end

  always_comb begin
    sel_cnt = '0;
    case (io_pcIn_bits_pcType)
      4'd0:    sel_cnt = cnt_run_q;
      4'd1:    sel_cnt = cnt_in_q;
      4'd2:    sel_cnt = cnt_out_q;
      4'd3:    sel_cnt = cnt_stall_q;
      default: sel_cnt = '0;
    endcase
  end

  // Requests addressed to us turn into responses; all other ring traffic passes through.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      io_pcOut_valid         <= 1'b0;
      io_pcOut_bits_request  <= 1'b0;
      io_pcOut_bits_moduleId <= '0;
      io_pcOut_bits_portId   <= '0;
      io_pcOut_bits_pcValue  <= '0;
      io_pcOut_bits_pcType   <= '0;
    end else begin
      io_pcOut_valid         <= io_pcIn_valid;
      io_pcOut_bits_moduleId <= io_pcIn_bits_moduleId;
      io_pcOut_bits_portId   <= io_pcIn_bits_portId;
      io_pcOut_bits_pcType   <= io_pcIn_bits_pcType;
      if (io_pcIn_valid && io_pcIn_bits_request && io_pcIn_bits_moduleId == MODULE_ID) begin
        io_pcOut_bits_request <= 1'b0;
        io_pcOut_bits_pcValue <= sel_cnt[15:0];
      end else begin
        io_pcOut_bits_request <= io_pcIn_bits_request;
        io_pcOut_bits_pcValue <= io_pcIn_bits_pcValue;
      end
    end
  end

endmodule

// File: tb/tb_page_rank_top.sv
// Bench for page_rank_top: job-level reference model checked every cycle,
// directed jobs pinning known sums, then randomized jobs and ring traffic.
module tb_page_rank_top;
  localparam logic [31:0] RANK = 32'd1024;
  localparam logic [15:0] MID  = 16'd1;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_in_ready, io_in_valid, io_in_bits_done;
  logic [31:0] io_in_bits_startPageId, io_in_bits_length;
  logic        io_out_ready, io_out_valid;
  logic [31:0] io_out_bits_out;
  logic        io_pcIn_valid, io_pcIn_bits_request;
  logic [15:0] io_pcIn_bits_moduleId, io_pcIn_bits_pcValue;
  logic [7:0]  io_pcIn_bits_portId;
  logic [3:0]  io_pcIn_bits_pcType;
  logic        io_pcOut_valid, io_pcOut_bits_request;
  logic [15:0] io_pcOut_bits_moduleId, io_pcOut_bits_pcValue;
  logic [7:0]  io_pcOut_bits_portId;
  logic [3:0]  io_pcOut_bits_pcType;

  page_rank_top #(.INIT_RANK(RANK), .MODULE_ID(MID)) dut (
    .clk(clk), .reset(reset),
    .io_in_ready(io_in_ready), .io_in_valid(io_in_valid),
    .io_in_bits_done(io_in_bits_done), .io_in_bits_startPageId(io_in_bits_startPageId),
    .io_in_bits_length(io_in_bits_length),
    .io_out_ready(io_out_ready), .io_out_valid(io_out_valid), .io_out_bits_out(io_out_bits_out),
    .io_pcIn_valid(io_pcIn_valid), .io_pcIn_bits_request(io_pcIn_bits_request),
    .io_pcIn_bits_moduleId(io_pcIn_bits_moduleId), .io_pcIn_bits_portId(io_pcIn_bits_portId),
    .io_pcIn_bits_pcValue(io_pcIn_bits_pcValue), .io_pcIn_bits_pcType(io_pcIn_bits_pcType),
    .io_pcOut_valid(io_pcOut_valid), .io_pcOut_bits_request(io_pcOut_bits_request),
    .io_pcOut_bits_moduleId(io_pcOut_bits_moduleId), .io_pcOut_bits_portId(io_pcOut_bits_portId),
    .io_pcOut_bits_pcValue(io_pcOut_bits_pcValue), .io_pcOut_bits_pcType(io_pcOut_bits_pcType)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit rand_pc = 0;

  // Reference model: job phase (0 idle, 1 sweeping, 2 result pending) plus event tallies.
  int          m_phase;
  logic [31:0] m_left, m_pending, m_result, m_jobs;
  logic [31:0] n_run, n_in, n_out, n_stall;
  logic        e_valid, e_req;
  logic [15:0] e_mid, e_val;
  logic [7:0]  e_port;
  logic [3:0]  e_type;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [31:0] rank_sum(input logic [31:0] start, input logic [31:0] len);
    logic [31:0] s = 0;
    logic [31:0] p;
    for (int i = 0; i < int'(len); i++) begin
      p = start + i;
      s = s + (RANK >> (p % 4));
    end
    return s;
  endfunction

  function automatic logic [15:0] counter_of(input logic [3:0] t);
    logic [31:0] v;
    case (t)
      4'd0: v = n_run;
      4'd1: v = n_in;
      4'd2: v = n_out;
      4'd3: v = n_stall;
      default: v = 0;
    endcase
    return v[15:0];
  endfunction

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_pending = 0; m_result = 0; m_jobs = 0;
    n_run = 0; n_in = 0; n_out = 0; n_stall = 0;
    e_valid = 0; e_req = 0; e_mid = 0; e_val = 0; e_port = 0; e_type = 0;
  endtask

  task automatic model_edge();
    if (!reset) begin
      model_reset();
      return;
    end
    e_valid = io_pcIn_valid; e_req = io_pcIn_bits_request; e_mid = io_pcIn_bits_moduleId;
    e_port = io_pcIn_bits_portId; e_type = io_pcIn_bits_pcType; e_val = io_pcIn_bits_pcValue;
    if (io_pcIn_valid && io_pcIn_bits_request && io_pcIn_bits_moduleId == MID) begin
      e_req = 0;
      e_val = counter_of(io_pcIn_bits_pcType);
    end
    case (m_phase)
      0: if (io_in_valid) begin
        n_in++;
        if (io_in_bits_done) begin
          m_result = m_jobs; m_phase = 2;
        end else if (io_in_bits_length == 0) begin
          m_result = 0; m_jobs++; m_phase = 2;
        end else begin
          m_pending = rank_sum(io_in_bits_startPageId, io_in_bits_length);
          m_left = io_in_bits_length; m_phase = 1;
        end
      end
      1: begin
        n_run++; m_left--;
        if (m_left == 0) begin
          m_result = m_pending; m_jobs++; m_phase = 2;
        end
      end
      default: if (io_out_ready) begin
        n_out++; m_phase = 0;
      end else n_stall++;
    endcase
  endtask

  task automatic compare();
    chk("in_ready", {31'd0, io_in_ready}, {31'd0, m_phase == 0});
    chk("out_valid", {31'd0, io_out_valid}, {31'd0, m_phase == 2});
    if (m_phase == 2) chk("out_bits", io_out_bits_out, m_result);
    chk("pc_valid", {31'd0, io_pcOut_valid}, {31'd0, e_valid});
    chk("pc_request", {31'd0, io_pcOut_bits_request}, {31'd0, e_req});
    chk("pc_moduleId", {16'd0, io_pcOut_bits_moduleId}, {16'd0, e_mid});
    chk("pc_portId", {24'd0, io_pcOut_bits_portId}, {24'd0, e_port});
    chk("pc_pcType", {28'd0, io_pcOut_bits_pcType}, {28'd0, e_type});
    chk("pc_pcValue", {16'd0, io_pcOut_bits_pcValue}, {16'd0, e_val});
  endtask

  task automatic step();
    if (rand_pc) begin
      io_pcIn_valid         = 1'($urandom);
      io_pcIn_bits_request  = 1'($urandom);
      io_pcIn_bits_moduleId = ($urandom % 3 == 0) ? 16'($urandom) : MID;
      io_pcIn_bits_portId   = 8'($urandom);
      io_pcIn_bits_pcValue  = 16'($urandom);
      io_pcIn_bits_pcType   = 4'($urandom % 6);
    end
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic do_job(input logic [31:0] start, input logic [31:0] len, input bit done,
                        input int stall, output logic [31:0] got, output int lat);
    int cyc;
    io_out_ready = 0;
    io_in_valid = 1; io_in_bits_done = done;
    io_in_bits_startPageId = start; io_in_bits_length = len;
    step();
    cyc = 1;
    while (!io_out_valid && cyc < 2000) begin
      io_in_bits_startPageId = $urandom; io_in_bits_length = $urandom % 8;
      io_in_bits_done = 1'($urandom);
      step();
      cyc++;
    end
    lat = cyc;
    chk("job_latency", lat, (done || len == 0) ? 1 : len + 1);
    io_in_valid = 0;
    repeat (stall) step();
    got = io_out_bits_out;
    io_out_ready = 1;
    step();
    io_out_ready = 0;
    $display("job start=%0h len=%0d done=%0d stall=%0d -> out=%0d lat=%0d", start, len, done, stall, got, lat);
  endtask

  task automatic pc_read(input logic [15:0] mid, input logic [3:0] t, output logic [15:0] v);
    io_pcIn_valid = 1; io_pcIn_bits_request = 1; io_pcIn_bits_moduleId = mid;
    io_pcIn_bits_portId = 8'h5a; io_pcIn_bits_pcValue = 16'hbeef; io_pcIn_bits_pcType = t;
    step();
    v = io_pcOut_bits_pcValue;
    io_pcIn_valid = 0; io_pcIn_bits_request = 0;
    $display("perf read mid=%0d type=%0d -> valid=%0d req=%0d value=%0d", mid, t, io_pcOut_valid, io_pcOut_bits_request, v);
  endtask

  task automatic mid_reset();
    #2 reset = 0;
    #1;
    model_reset();
    chk("rst_in_ready", {31'd0, io_in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, io_out_valid}, 32'd0);
    chk("rst_out_bits", io_out_bits_out, 32'd0);
    chk("rst_pc_valid", {31'd0, io_pcOut_valid}, 32'd0);
    @(negedge clk);
    reset = 1;
    step();
  endtask

  initial begin
    logic [31:0] got;
    logic [15:0] pv;
    int lat;
    model_reset();
    reset = 0;
    io_in_valid = 0; io_in_bits_done = 0; io_in_bits_startPageId = 0; io_in_bits_length = 0;
    io_out_ready = 0;
    io_pcIn_valid = 0; io_pcIn_bits_request = 0; io_pcIn_bits_moduleId = 0;
    io_pcIn_bits_portId = 0; io_pcIn_bits_pcValue = 0; io_pcIn_bits_pcType = 0;
    repeat (3) @(posedge clk);
    #1;
    compare();
    chk("reset_out_bits", io_out_bits_out, 32'd0);
    @(negedge clk);
    reset = 1;
    step();

    do_job(32'd0, 32'd100, 1'b0, 0, got, lat);
    chk("sum_0_100", got, 32'd48000);
    chk("lat_0_100", lat, 32'd101);
    chk("in_ready_after", {31'd0, io_in_ready}, 32'd1);
    pc_read(MID, 4'd0, pv);
    chk("pc_run_cycles", {16'd0, pv}, 32'd100);
    chk("pc_resp_req", {31'd0, io_pcOut_bits_request}, 32'd0);
    pc_read(MID, 4'd1, pv);
    chk("pc_in_hs", {16'd0, pv}, 32'd1);
    pc_read(16'd7, 4'd0, pv);
    chk("pc_fwd_value", {16'd0, pv}, 32'hbeef);
    chk("pc_fwd_req", {31'd0, io_pcOut_bits_request}, 32'd1);
    chk("pc_fwd_mid", {16'd0, io_pcOut_bits_moduleId}, 32'd7);

    do_job(32'd3, 32'd2, 1'b0, 5, got, lat);
    chk("sum_3_2", got, 32'd1152);
    pc_read(MID, 4'd3, pv);
    chk("pc_stall", {16'd0, pv}, 32'd5);
    pc_read(MID, 4'd2, pv);
    chk("pc_out_hs", {16'd0, pv}, 32'd2);

    io_in_valid = 1; io_in_bits_done = 0; io_in_bits_startPageId = 0; io_in_bits_length = 50;
    step();
    io_in_valid = 0;
    repeat (10) step();
    mid_reset();
    pc_read(MID, 4'd0, pv);
    chk("pc_run_after_rst", {16'd0, pv}, 32'd0);

    do_job(32'd9, 32'd0, 1'b0, 0, got, lat);
    chk("len0_out", got, 32'd0);
    chk("len0_lat", lat, 32'd1);
    do_job(32'd0, 32'd0, 1'b1, 1, got, lat);
    chk("done_count", got, 32'd1);

    rand_pc = 1;
    for (int j = 0; j < 150; j++) begin
      logic [31:0] st, ln;
      bit dn;
      st = ($urandom % 4 == 0) ? 32'hffff_fff0 + ($urandom % 16) : $urandom;
      ln = ($urandom % 8 == 0) ? 0 : $urandom % 24 + 1;
      dn = ($urandom % 10 == 0);
      do_job(st, ln, dn, $urandom % 4, got, lat);
      if (j == 75) begin
        io_in_valid = 1; io_in_bits_done = 0; io_in_bits_length = 30;
        step();
        io_in_valid = 0;
        repeat ($urandom % 20) step();
        mid_reset();
      end
      repeat ($urandom % 3) step();
    end
    rand_pc = 0;
    io_pcIn_valid = 0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/page_rank_top.md
Name: page_rank_top

Overview:
Top-level wrapper of the PageRank accelerator. It accepts a job (start page id, page count) on a valid/ready input channel, sweeps the page range one page per cycle and accumulates a fixed-point rank sum, then returns the 32-bit result on a valid/ready output channel. A performance-counter ring port (pcIn → pcOut) exposes internal activity counters to the host.

Parameters:
INIT_RANK, 1024, fixed-point base rank of a page before degree scaling
MODULE_ID, 1, id this block answers to on the perf-counter ring

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (low = reset asserted)
io_in_ready  out  1  job input channel ready
io_in_valid  in  1  job input channel valid
io_in_bits_done  in  1  terminate token; no range sweep
io_in_bits_startPageId  in  32  first page id of job
io_in_bits_length  in  32  number of pages in job
io_out_ready  in  1  result channel ready
io_out_valid  out  1  result channel valid
io_out_bits_out  out  32  result value
io_pcIn_valid  in  1  perf-counter ring input valid
io_pcIn_bits_request  in  1  1 = read request, 0 = response in transit
io_pcIn_bits_moduleId  in  16  target module id
io_pcIn_bits_portId  in  8  target port id
io_pcIn_bits_pcValue  in  16  counter value field
io_pcIn_bits_pcType  in  4  counter selector
io_pcOut_valid  out  1  perf-counter ring output valid
io_pcOut_bits_request  out  1
io_pcOut_bits_moduleId  out  16
io_pcOut_bits_portId  out  8
io_pcOut_bits_pcValue  out  16
io_pcOut_bits_pcType  out  4

Behaviour:
- Reset (reset low, async): state IDLE, io_in_ready=1, io_out_valid=0, io_out_bits_out=0, accumulator, page pointer, remaining count, job counter, all perf counters, and all io_pcOut_* outputs = 0.
- FSM states: IDLE, RUN, OUT. io_in_ready = 1 only in IDLE.
- IDLE: on io_in_valid & io_in_ready (handshake):
  - if done=1: result = number of non-done jobs completed since reset (32-bit, wrapping); go to OUT.
  - else if length=0: result = 0; go to OUT.
  - else: ptr=startPageId, rem=length, acc=0; go to RUN.
- RUN, one page per cycle: acc += INIT_RANK >> (ptr mod 4); ptr += 1 (32-bit wrap); rem -= 1. When rem reaches 0, latch acc (including the final page) as result, increment job counter, go to OUT.
- Sum arithmetic: 32-bit unsigned, wraps silently.
- Latency: a job of length N accepted in cycle 0 raises io_out_valid in cycle N+1. Done-token and length=0 jobs raise io_out_valid in cycle 1.
- OUT: io_out_valid=1, io_out_bits_out=result, both stable until io_out_ready=1. The handshake cycle returns to IDLE; io_in_ready is 1 the following cycle. There is no input/output overlap.
- Perf counters (32-bit, wrapping), pcType:
  - 0 = cycles in RUN
  - 1 = input handshakes
  - 2 = output handshakes
  - 3 = output stall cycles (io_out_valid & !io_out_ready)
  - other pcType values read as 0.
- Perf ring, registered with 1-cycle latency:
  - If io_pcIn_valid & request=1 & moduleId==MODULE_ID: next cycle pcOut_valid=1, request=0, same moduleId/portId/pcType, pcValue = low 16 bits of the selected counter.
  - Otherwise pcOut copies all pcIn fields unchanged.
  - pcIn_valid=0 produces pcOut_valid=0 next cycle.
- Reset asserted mid-job aborts the job immediately; the result is lost and the block is in IDLE after reset deasserts.

Test Plan:
- Reset low then high; single job start=0, length=100, out_ready held 1 → io_out_valid in cycle 101 after acceptance, out=48000, then io_in_ready=1.
- Job start=3, length=2 → out = 128+1024 = 1152. Hold out_ready=0 for 5 cycles → valid/out stable. Then a perf read of pcType=3 → pcValue=5.
- length=0 → out=0 one cycle after acceptance. Then a done token → out=1 (count of non-done jobs completed so far, including the length=0 job).
- Perf read: request=1, moduleId=MODULE_ID, pcType=0 after the 100-page job → next cycle pcOut_valid=1, request=0, pcValue=100. Same read with moduleId=7 → fields forwarded unchanged.
- io_in_valid held high during RUN/OUT → no second acceptance (pcType 1 count = 1 per job).
- Reset pulsed low mid-RUN → out_valid=0 immediately, io_in_ready=1, all counters 0.
